// File: rtl/cd_frame_ring.sv
// rtl/cd_frame_ring.sv - N-frame byte/word dual-view frame buffer ring
//
// Purpose: a ring of 2**N_WIDTH frames, each 2**A_WIDTH 32-bit words, that
// sits between the CDBUS byte engines and the 32-bit host bus. The host views a
// frame as words; the byte side views it as bytes. Every committed frame
// carries a flags byte and a byte length.
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   mm_address/byteenable/read/   host word port on the host-side frame
//   write/writedata/readdata      (readdata valid 1 cycle after mm_read)
//   rd_addr/rd_en/rd_byte         byte read port on the head frame
//   rd_done, rd_flush             release the head frame / clear the ring
//   rd_flags, rd_len              flags and byte length of the head frame
//   unread, frame_cnt             pending-frame status
//   wr_addr/wr_en/wr_byte         byte write port on the write frame
//   switch, wr_flags, wr_len      commit the write frame with flags and length
//   switch_fail, drop, drop_cnt   commit refused / oldest dropped / drop count
module cd_frame_ring #(
  parameter int A_WIDTH   = 6,
  parameter int N_WIDTH   = 2,
  parameter int MM4RD     = 1,
  parameter int OVERWRITE = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [A_WIDTH-1:0]   mm_address,
  input  logic [3:0]           mm_byteenable,
  input  logic                 mm_read,
  output logic [31:0]          mm_readdata,
  input  logic                 mm_write,
  input  logic [31:0]          mm_writedata,
  output logic [7:0]           rd_byte,
  input  logic [A_WIDTH+1:0]   rd_addr,
  input  logic                 rd_en,
  input  logic                 rd_done,
  input  logic                 rd_flush,
  output logic [7:0]           rd_flags,
  output logic [A_WIDTH+2:0]   rd_len,
  output logic                 unread,
  output logic [N_WIDTH-1:0]   frame_cnt,
  input  logic [7:0]           wr_byte,
  input  logic [A_WIDTH+1:0]   wr_addr,
  input  logic                 wr_en,
  input  logic                 switch,
  input  logic [7:0]           wr_flags,
  input  logic [A_WIDTH+2:0]   wr_len,
  output logic                 switch_fail,
  output logic                 drop,
  output logic [7:0]           drop_cnt
);

  localparam int FRAMES = 2**N_WIDTH;
  localparam int DEPTH  = 2**(N_WIDTH+A_WIDTH);
  localparam int AW     = N_WIDTH + A_WIDTH;
  localparam logic [N_WIDTH-1:0] CNT_FULL = '1;

  logic [N_WIDTH-1:0] wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d, cnt_q, cnt_d;
  logic               lock_q, lock_d, fail_q, fail_d, drop_q, drop_d;
  logic [7:0]         drop_cnt_q, drop_cnt_d;
  logic               commit, done_ok, room, rd_strobe;

  logic [7:0]         flags_q [FRAMES];
  logic [A_WIDTH+2:0] len_q   [FRAMES];
  logic [7:0]         rd_flags_q, rd_byte_q;
  logic [A_WIDTH+2:0] rd_len_q;
  logic [31:0]        mm_rdata_q;

  logic [3:0]         lane_we;
  logic [AW-1:0]      waddr, host_raddr, byte_raddr;
  logic [31:0]        wdata, host_word, byte_word;

  // Only one side owns the write port; the other side is the reader.
  always_comb begin
    lane_we = '0;
    waddr   = '0;
    wdata   = '0;
    if (MM4RD != 0) begin
      waddr   = {wr_sel_q, wr_addr[A_WIDTH+1:2]};
      wdata   = {4{wr_byte}};
      lane_we = wr_en ? (4'b0001 << wr_addr[1:0]) : 4'b0000;
    end else begin
      waddr   = {wr_sel_q, mm_address};
      wdata   = mm_writedata;
      lane_we = mm_write ? mm_byteenable : 4'b0000;
    end
  end

  assign host_raddr = {((MM4RD != 0) ? rd_sel_q : wr_sel_q), mm_address};
  assign byte_raddr = {rd_sel_q, rd_addr[A_WIDTH+1:2]};

  // One RAM per byte lane so byte-granular writes map onto plain RAMs.
  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [7:0] mem [DEPTH];
    always_ff @(posedge clk) begin
      if (lane_we[g]) mem[waddr] <= wdata[8*g +: 8];
    end
    assign host_word[8*g +: 8] = mem[host_raddr];
    assign byte_word[8*g +: 8] = mem[byte_raddr];
  end

  // The reader locks the head on whichever side reads frame data.
  assign rd_strobe = (MM4RD != 0) ? mm_read : rd_en;

  always_comb begin
    wr_sel_d   = wr_sel_q;
    rd_sel_d   = rd_sel_q;
    cnt_d      = cnt_q;
    lock_d     = lock_q;
    drop_cnt_d = drop_cnt_q;
    fail_d     = 1'b0;
    drop_d     = 1'b0;
    commit     = 1'b0;
    done_ok    = rd_done && (cnt_q != '0);
    // A same-cycle release frees a slot before the commit is judged.
    room       = (cnt_q != CNT_FULL) || done_ok;
    if (rd_flush) begin
      wr_sel_d   = '0;
      rd_sel_d   = '0;
      cnt_d      = '0;
      lock_d     = 1'b0;
      drop_cnt_d = '0;
    end else begin
      if (done_ok) begin
        rd_sel_d = rd_sel_q + 1'b1;
        cnt_d    = cnt_q - 1'b1;
      end
      if (rd_done) begin
        lock_d = 1'b0;
      end else if (rd_strobe && (cnt_q != '0)) begin
        lock_d = 1'b1;
      end
      if (switch) begin
        if (room) begin
          commit   = 1'b1;
          wr_sel_d = wr_sel_q + 1'b1;
          cnt_d    = cnt_d + 1'b1;
        end else if ((OVERWRITE != 0) && !lock_q) begin
          // Full ring: the oldest frame is sacrificed, count stays full.
          commit   = 1'b1;
          wr_sel_d = wr_sel_q + 1'b1;
          rd_sel_d = rd_sel_q + 1'b1;
          drop_d   = 1'b1;
          if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
        end else begin
          fail_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_sel_q   <= '0;
      rd_sel_q   <= '0;
      cnt_q      <= '0;
      lock_q     <= 1'b0;
      fail_q     <= 1'b0;
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
      rd_flags_q <= '0;
      rd_len_q   <= '0;
      rd_byte_q  <= '0;
      mm_rdata_q <= '0;
      for (int i = 0; i < FRAMES; i++) begin
        flags_q[i] <= '0;
        len_q[i]   <= '0;
      end
    end else begin
      wr_sel_q   <= wr_sel_d;
      rd_sel_q   <= rd_sel_d;
      cnt_q      <= cnt_d;
      lock_q     <= lock_d;
      fail_q     <= fail_d;
      drop_q     <= drop_d;
      drop_cnt_q <= drop_cnt_d;
      if (commit) begin
        flags_q[wr_sel_q] <= wr_flags;
        len_q[wr_sel_q]   <= wr_len;
      end
      rd_flags_q <= flags_q[rd_sel_q];
      rd_len_q   <= len_q[rd_sel_q];
      if (mm_read) mm_rdata_q <= host_word;
      if (rd_en)   rd_byte_q  <= byte_word[{rd_addr[1:0], 3'b000} +: 8];
    end
  end

  assign mm_readdata = mm_rdata_q;
  assign rd_byte     = rd_byte_q;
  assign rd_flags    = rd_flags_q;
  assign rd_len      = rd_len_q;
  assign unread      = (cnt_q != '0);
  assign frame_cnt   = cnt_q;
  assign switch_fail = fail_q;
  assign drop        = drop_q;
  assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_cd_frame_ring.sv
// tb/tb_cd_frame_ring.sv - bench for cd_frame_ring (byte-write/overwrite and host-write/no-overwrite instances)
module tb_cd_frame_ring;

  localparam int AW = 6;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [AW-1:0] mm_address = '0;
  logic [3:0]  mm_byteenable = '0;
  logic        mm_read = 1'b0, mm_write = 1'b0;
  logic [31:0] mm_writedata = '0;
  logic [AW+1:0] rd_addr = '0, wr_addr = '0;
  logic        rd_en = 1'b0, rd_done = 1'b0, rd_flush = 1'b0;
  logic [7:0]  wr_byte = '0, wr_flags = '0;
  logic        wr_en = 1'b0, switch = 1'b0;
  logic [AW+2:0] wr_len = '0;

  logic [31:0] mm_readdata_1, mm_readdata_0;
  logic [7:0]  rd_byte_1, rd_byte_0, rd_flags_1, rd_flags_0, drop_cnt_1, drop_cnt_0;
  logic [AW+2:0] rd_len_1, rd_len_0;
  logic        unread_1, unread_0, switch_fail_1, switch_fail_0, drop_1, drop_0;
  logic [1:0]  frame_cnt_1, frame_cnt_0;

  always #5 clk = ~clk;

  cd_frame_ring #(.A_WIDTH(AW), .N_WIDTH(2), .MM4RD(1), .OVERWRITE(1)) u1 (
    .clk(clk), .reset_n(reset_n), .mm_address(mm_address), .mm_byteenable(mm_byteenable),
    .mm_read(mm_read), .mm_readdata(mm_readdata_1), .mm_write(mm_write), .mm_writedata(mm_writedata),
    .rd_byte(rd_byte_1), .rd_addr(rd_addr), .rd_en(rd_en), .rd_done(rd_done), .rd_flush(rd_flush),
    .rd_flags(rd_flags_1), .rd_len(rd_len_1), .unread(unread_1), .frame_cnt(frame_cnt_1),
    .wr_byte(wr_byte), .wr_addr(wr_addr), .wr_en(wr_en), .switch(switch), .wr_flags(wr_flags),
    .wr_len(wr_len), .switch_fail(switch_fail_1), .drop(drop_1), .drop_cnt(drop_cnt_1));

  cd_frame_ring #(.A_WIDTH(AW), .N_WIDTH(2), .MM4RD(0), .OVERWRITE(0)) u0 (
    .clk(clk), .reset_n(reset_n), .mm_address(mm_address), .mm_byteenable(mm_byteenable),
    .mm_read(mm_read), .mm_readdata(mm_readdata_0), .mm_write(mm_write), .mm_writedata(mm_writedata),
    .rd_byte(rd_byte_0), .rd_addr(rd_addr), .rd_en(rd_en), .rd_done(rd_done), .rd_flush(rd_flush),
    .rd_flags(rd_flags_0), .rd_len(rd_len_0), .unread(unread_0), .frame_cnt(frame_cnt_0),
    .wr_byte(wr_byte), .wr_addr(wr_addr), .wr_en(wr_en), .switch(switch), .wr_flags(wr_flags),
    .wr_len(wr_len), .switch_fail(switch_fail_0), .drop(drop_0), .drop_cnt(drop_cnt_0));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic       sw;
    logic       done;
    logic       mrd;
    logic [7:0] flags;
    logic [1:0] cnt1;
    logic       fail1;
    logic       drop1;
    logic [7:0] dcnt1;
    logic [7:0] rfl1;
    logic [1:0] cnt0;
    logic       fail0;
  } vec_t;

  vec_t vecs [13];

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_bytes [4];

    //            sw    done  mrd   flags  | cnt1  fail1 drop1 dcnt1 rfl1   | cnt0  fail0
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h01, 2'd1, 1'b0, 1'b0, 8'd0, 8'h5A, 2'd1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h02, 2'd2, 1'b0, 1'b0, 8'd0, 8'h01, 2'd2, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'h03, 2'd3, 1'b0, 1'b0, 8'd0, 8'h01, 2'd3, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 8'h04, 2'd3, 1'b0, 1'b1, 8'd1, 8'h01, 2'd3, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 2'd3, 1'b0, 1'b0, 8'd1, 8'h02, 2'd3, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 8'h00, 2'd3, 1'b0, 1'b0, 8'd1, 8'h02, 2'd3, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 8'h05, 2'd3, 1'b1, 1'b0, 8'd1, 8'h02, 2'd3, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 8'h06, 2'd3, 1'b0, 1'b0, 8'd1, 8'h02, 2'd3, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 2'd3, 1'b0, 1'b0, 8'd1, 8'h03, 2'd3, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 2'd2, 1'b0, 1'b0, 8'd1, 8'h03, 2'd2, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 8'h07, 2'd3, 1'b0, 1'b0, 8'd1, 8'h04, 2'd3, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 8'h08, 2'd3, 1'b0, 1'b1, 8'd2, 8'h04, 2'd3, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 8'h00, 2'd3, 1'b0, 1'b0, 8'd2, 8'h06, 2'd3, 1'b0};

    // Reset state
    step();
    chk("reset frame_cnt1", 32'(frame_cnt_1), 32'd0);
    chk("reset unread1", 32'(unread_1), 32'd0);
    chk("reset readdata1", mm_readdata_1, 32'd0);
    chk("reset rd_flags1", 32'(rd_flags_1), 32'd0);
    chk("reset drop_cnt1", 32'(drop_cnt_1), 32'd0);
    chk("reset rd_byte0", 32'(rd_byte_0), 32'd0);
    chk("reset switch_fail0", 32'(switch_fail_0), 32'd0);
    reset_n = 1'b1;

    // Basic byte-write transfer, host reads the head frame
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1;
      wr_addr = 8'(i);
      wr_byte = 8'(8'h11 * (i + 1));
      step();
    end
    wr_en = 1'b0;
    switch = 1'b1; wr_flags = 8'h5A; wr_len = 9'd4;
    step();
    switch = 1'b0;
    chk("basic frame_cnt1", 32'(frame_cnt_1), 32'd1);
    chk("basic unread1", 32'(unread_1), 32'd1);
    chk("basic frame_cnt0", 32'(frame_cnt_0), 32'd1);
    step();
    chk("basic rd_flags1", 32'(rd_flags_1), 32'h5A);
    chk("basic rd_len1", 32'(rd_len_1), 32'd4);
    mm_read = 1'b1; mm_address = '0;
    step();
    mm_read = 1'b0;
    chk("basic readdata1", mm_readdata_1, 32'h44332211);
    rd_flush = 1'b1;
    step();
    rd_flush = 1'b0;
    chk("flush frame_cnt1", 32'(frame_cnt_1), 32'd0);
    chk("flush frame_cnt0", 32'(frame_cnt_0), 32'd0);

    // Fill / overwrite / lock / simultaneous events
    for (int i = 0; i < 13; i++) begin
      switch = vecs[i].sw;
      rd_done = vecs[i].done;
      mm_read = vecs[i].mrd;
      mm_address = '0;
      wr_flags = vecs[i].flags;
      wr_len = {1'b0, vecs[i].flags};
      step();
      switch = 1'b0; rd_done = 1'b0; mm_read = 1'b0;
      chk($sformatf("v%0d frame_cnt1", i), 32'(frame_cnt_1), 32'(vecs[i].cnt1));
      chk($sformatf("v%0d unread1", i), 32'(unread_1), 32'(vecs[i].cnt1 != 2'd0));
      chk($sformatf("v%0d switch_fail1", i), 32'(switch_fail_1), 32'(vecs[i].fail1));
      chk($sformatf("v%0d drop1", i), 32'(drop_1), 32'(vecs[i].drop1));
      chk($sformatf("v%0d drop_cnt1", i), 32'(drop_cnt_1), 32'(vecs[i].dcnt1));
      chk($sformatf("v%0d rd_flags1", i), 32'(rd_flags_1), 32'(vecs[i].rfl1));
      chk($sformatf("v%0d frame_cnt0", i), 32'(frame_cnt_0), 32'(vecs[i].cnt0));
      chk($sformatf("v%0d switch_fail0", i), 32'(switch_fail_0), 32'(vecs[i].fail0));
    end

    // Three more overwrites bring drop_cnt to 5, then release one frame
    for (int i = 0; i < 3; i++) begin
      switch = 1'b1; wr_flags = 8'h10;
      step();
      switch = 1'b0;
      chk($sformatf("ovw%0d drop1", i), 32'(drop_1), 32'd1);
      chk($sformatf("ovw%0d drop_cnt1", i), 32'(drop_cnt_1), 32'(3 + i));
    end
    rd_done = 1'b1;
    step();
    rd_done = 1'b0;
    chk("pre-flush frame_cnt1", 32'(frame_cnt_1), 32'd2);
    chk("pre-flush drop_cnt1", 32'(drop_cnt_1), 32'd5);

    // Flush wins over a same-cycle switch
    rd_flush = 1'b1; switch = 1'b1;
    step();
    rd_flush = 1'b0; switch = 1'b0;
    chk("flush+sw frame_cnt1", 32'(frame_cnt_1), 32'd0);
    chk("flush+sw unread1", 32'(unread_1), 32'd0);
    chk("flush+sw drop_cnt1", 32'(drop_cnt_1), 32'd0);
    chk("flush+sw switch_fail1", 32'(switch_fail_1), 32'd0);
    chk("flush+sw drop1", 32'(drop_1), 32'd0);
    chk("flush+sw frame_cnt0", 32'(frame_cnt_0), 32'd0);
    chk("flush+sw switch_fail0", 32'(switch_fail_0), 32'd0);

    // Asynchronous reset in the middle of a write
    switch = 1'b1; wr_flags = 8'h09;
    step();
    switch = 1'b0;
    mm_read = 1'b1; mm_address = '0;
    step();
    mm_read = 1'b0;
    chk("pre-reset readdata1", mm_readdata_1, 32'h44332211);
    chk("pre-reset rd_flags1", 32'(rd_flags_1), 32'h09);
    wr_en = 1'b1; wr_addr = 8'd5; wr_byte = 8'h77;
    #2 reset_n = 1'b0;
    #1;
    chk("async reset frame_cnt1", 32'(frame_cnt_1), 32'd0);
    chk("async reset unread1", 32'(unread_1), 32'd0);
    chk("async reset readdata1", mm_readdata_1, 32'd0);
    chk("async reset rd_flags1", 32'(rd_flags_1), 32'd0);
    wr_en = 1'b0;
    step();
    reset_n = 1'b1;

    // Host writes with byte enables, byte side reads back
    mm_write = 1'b1; mm_address = 6'd3; mm_byteenable = 4'b1111; mm_writedata = 32'h0;
    step();
    mm_byteenable = 4'b0101; mm_writedata = 32'hAABBCCDD;
    step();
    mm_write = 1'b0;
    switch = 1'b1; wr_flags = 8'h33; wr_len = 9'd16;
    step();
    switch = 1'b0;
    chk("be frame_cnt0", 32'(frame_cnt_0), 32'd1);
    exp_bytes[0] = 8'hDD; exp_bytes[1] = 8'h00; exp_bytes[2] = 8'hBB; exp_bytes[3] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      rd_en = 1'b1; rd_addr = 8'(12 + i);
      step();
      chk($sformatf("be rd_byte0 addr %0d", 12 + i), 32'(rd_byte_0), 32'(exp_bytes[i]));
    end
    rd_en = 1'b0; rd_addr = 8'd12;
    step();
    chk("be rd_byte0 hold", 32'(rd_byte_0), 32'h00);
    chk("be rd_flags0", 32'(rd_flags_0), 32'h33);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cd_frame_ring.md
Name: cd_frame_ring

Overview:
- N-frame byte/word dual-view frame buffer ring; successor to the two-frame ping-pong packet RAM between the CDBUS byte engines (rx/tx) and the 32-bit memory-mapped host bus.
- Generalises the frame count.
- Stores a byte length alongside flags per frame.
- Exposes the pending-frame count.
- Adds an optional overwrite-oldest mode with reader lock protection and a drop counter.

Parameters:
- A_WIDTH, 6, word address width per frame (frame = 2**A_WIDTH 32-bit words = 2**(A_WIDTH+2) bytes)
- N_WIDTH, 2, log2 of frame count (frames = 2**N_WIDTH, pending capacity = 2**N_WIDTH-1)
- MM4RD, 1, 1: host reads the head (read) frame, byte side writes; 0: host writes the write frame, byte side reads
- OVERWRITE, 0, 1: switch when full drops the oldest pending frame instead of failing

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- mm_address  in  A_WIDTH  host word address in the host-side frame
- mm_byteenable  in  4  host byte lanes for write
- mm_read  in  1  host read strobe
- mm_readdata  out  32  host read data, {byte3,byte2,byte1,byte0}
- mm_write  in  1  host write strobe (used only when MM4RD=0)
- mm_writedata  in  32  host write data
- rd_byte  out  8  byte-side read data
- rd_addr  in  A_WIDTH+2  byte address in the head frame
- rd_en  in  1  byte-side read strobe
- rd_done  in  1  release the head frame
- rd_flush  in  1  clear all frames, return both pointers to 0
- rd_flags  out  8  flags of the head frame
- rd_len  out  A_WIDTH+3  byte length of the head frame
- unread  out  1  pending count != 0
- frame_cnt  out  N_WIDTH  number of pending frames
- wr_byte  in  8  byte-side write data (used only when MM4RD=1)
- wr_addr  in  A_WIDTH+2  byte address in the write frame
- wr_en  in  1  byte-side write strobe
- switch  in  1  commit the write frame
- wr_flags  in  8  flags committed with switch
- wr_len  in  A_WIDTH+3  byte length committed with switch
- switch_fail  out  1  one-cycle pulse: commit refused
- drop  out  1  one-cycle pulse: oldest frame discarded (OVERWRITE=1)
- drop_cnt  out  8  saturating count of drops

Behaviour:
- Reset values: all pointers, counts, lock, mm_readdata, rd_byte, rd_flags, rd_len, switch_fail, drop, drop_cnt = 0. RAM contents are not reset.
- State: wr_sel and rd_sel, N_WIDTH bits each, wrap modulo 2**N_WIDTH. frame_cnt = pending frames; full when frame_cnt == 2**N_WIDTH-1.
- Byte side: rd_addr[1:0] selects the lane, rd_addr[A+1:2] selects the word; write side decodes wr_addr the same way.
- Latency: rd_byte is valid 1 cycle after rd_en; mm_readdata is valid 1 cycle after mm_read. Both hold their value when the strobe is low.
- Host frame select: rd_sel if MM4RD=1, else wr_sel.
- Writes:
  - MM4RD=1: the byte port writes frame wr_sel.
  - MM4RD=0: the host writes frame wr_sel per byteenable lane; wr_en is ignored.
- rd_flags and rd_len are registered from the frame at rd_sel each cycle (1-cycle lag after a pointer change).
- Head lock:
  - Set by rd_en (MM4RD=0) or mm_read (MM4RD=1) while frame_cnt != 0.
  - Cleared by rd_done or rd_flush.
- switch, not full: store wr_flags/wr_len at wr_sel, wr_sel+1, frame_cnt+1.
- switch, full:
  - OVERWRITE=0, or lock set: switch_fail=1; no state change.
  - OVERWRITE=1 and lock clear: commit as above, rd_sel+1, frame_cnt unchanged, drop=1, drop_cnt+1 saturating at 255.
- rd_done with frame_cnt != 0: rd_sel+1, frame_cnt-1, lock cleared. rd_done with frame_cnt == 0 is ignored.
- switch and rd_done in the same cycle:
  - Not full: both pointers advance, frame_cnt unchanged.
  - Full: rd_done is applied first, so the switch succeeds with no fail and no drop.
- rd_flush: highest priority. Pointers, frame_cnt, lock and drop_cnt go to 0; switch_fail=0 and drop=0 in that cycle; a same-cycle switch or rd_done is discarded.
- Read/write to the same frame while frame_cnt == 0 (rd_sel == wr_sel): read data is don't-care, with no corruption of other frames.
- Asynchronous reset mid-frame: control state clears immediately; RAM contents are unspecified.

Test Plan:
- Basic transfer, MM4RD=1, N_WIDTH=2: write bytes 0x11,0x22,0x33,0x44 to addr 0-3; switch with flags=0x5A, len=4 -> frame_cnt=1, unread=1, rd_flags=0x5A, rd_len=4; mm_read addr 0 -> next cycle mm_readdata=0x44332211.
- Fill, OVERWRITE=0: 3 switches -> frame_cnt=3; 4th switch -> switch_fail pulse for 1 cycle, wr_sel unchanged; rd_done -> frame_cnt=2; switch -> succeeds.
- Overwrite, OVERWRITE=1: 3 frames with flags 1,2,3, then switch flags 4 -> drop pulse, drop_cnt=1, frame_cnt=3, rd_flags=2. Repeat after an mm_read on the head -> switch_fail=1, no drop.
- Simultaneous events at full: switch+rd_done in the same cycle -> no fail, no drop, frame_cnt stays 3, head flags advance by one frame.
- Flush and reset: with frame_cnt=2 and drop_cnt=5, assert rd_flush together with switch -> frame_cnt=0, unread=0, drop_cnt=0, no switch_fail. Assert reset_n low mid-write -> all outputs 0 asynchronously.
- MM4RD=0 with byteenable: host writes 0xAABBCCDD with be=0101 to addr 3 over prior 0; switch -> rd_addr 12..15 read back DD,00,BB,00 with 1-cycle latency each.
